kamacore_hazard_scoreboard: RTL and testbench

- Producer-side companion to the pipeline bypass network: tracks every in-flight register write from issue until writeback.
- Per destination register it records a countdown until the result is forwardable.
- Raises a stall to ID when a source or destination register's result cannot yet be forwarded.
- Sits beside ID: issue side fed by ID/EX, completion side fed by WB.

---
 rtl/kamacore_hazard_scoreboard_if.sv | 36 +++
 rtl/kamacore_hazard_scoreboard.sv | 80 ++++++++
 tb/tb_kamacore_hazard_scoreboard.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/kamacore_hazard_scoreboard_if.sv
// Issue, completion and stall bundle between ID/EX/WB and the hazard scoreboard.
// The master side drives register addresses and events; the slave side returns stall and pending state.
interface kamacore_hazard_scoreboard_if #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int LAT_W = 3
);
    logic [AW-1:0]    rs1_a;
    logic             rs1_used;
    logic [AW-1:0]    rs2_a;
    logic             rs2_used;
    logic             issue_valid;
    logic             issue_we;
    logic [AW-1:0]    issue_rd;
    logic [LAT_W-1:0] issue_lat;
    logic             kill_ex;
    logic             wb_valid;
    logic [AW-1:0]    wb_rd;
    logic             stall;
    logic             busy;
    logic [NREGS-1:0] pending_mask;

    modport master (
        output rs1_a, rs1_used, rs2_a, rs2_used,
        output issue_valid, issue_we, issue_rd, issue_lat,
        output kill_ex, wb_valid, wb_rd,
        input  stall, busy, pending_mask
    );

    modport slave (
        input  rs1_a, rs1_used, rs2_a, rs2_used,
        input  issue_valid, issue_we, issue_rd, issue_lat,
        input  kill_ex, wb_valid, wb_rd,
        output stall, busy, pending_mask
    );
endinterface

// File: rtl/kamacore_hazard_scoreboard.sv
// Tracks in-flight register writes from issue to writeback and stalls ID on unforwardable operands.
// stall is combinational from ID inputs; pending state updates one cycle after issue/kill/wb.
module kamacore_hazard_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int LAT_W = 3
) (
    input logic                       clk,
    input logic                       rst_n,
    kamacore_hazard_scoreboard_if.slave sb
);
    logic [NREGS-1:0] pend_q, pend_d;
    logic [LAT_W-1:0] cnt_q [NREGS];
    logic [LAT_W-1:0] cnt_d [NREGS];
    logic             last_v_q, last_v_d;
    logic [AW-1:0]    last_rd_q, last_rd_d;

    logic rs1_haz, rs2_haz, waw_haz;
    logic accept, issue_wr, kill_hit, wb_hit;

    // A pending entry with a zero countdown is already on the bypass network, so reads proceed.
    assign rs1_haz = sb.rs1_used && (sb.rs1_a != '0) && pend_q[sb.rs1_a] && (cnt_q[sb.rs1_a] != '0);
    assign rs2_haz = sb.rs2_used && (sb.rs2_a != '0) && pend_q[sb.rs2_a] && (cnt_q[sb.rs2_a] != '0);
    assign waw_haz = sb.issue_we && (sb.issue_rd != '0) && pend_q[sb.issue_rd];

    assign sb.stall        = rs1_haz || rs2_haz || waw_haz;
    assign sb.busy         = |pend_q;
    assign sb.pending_mask = pend_q;

    assign accept   = sb.issue_valid && !sb.stall;
    assign issue_wr = accept && sb.issue_we && (sb.issue_rd != '0);
    assign kill_hit = sb.kill_ex && last_v_q;
    assign wb_hit   = sb.wb_valid && (sb.wb_rd != '0);

    always_comb begin
        pend_d    = pend_q;
        last_v_d  = 1'b0;
        last_rd_d = last_rd_q;
        for (int i = 0; i < NREGS; i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - LAT_W'(1) : '0;
            // Later assignments win: decrement < writeback < kill < issue.
            if (wb_hit && (sb.wb_rd == AW'(i))) begin
                pend_d[i] = 1'b0;
                cnt_d[i]  = '0;
            end
            if (kill_hit && (last_rd_q == AW'(i))) begin
                pend_d[i] = 1'b0;
                cnt_d[i]  = '0;
            end
            if (issue_wr && (sb.issue_rd == AW'(i))) begin
                pend_d[i] = 1'b1;
                cnt_d[i]  = sb.issue_lat;
            end
        end
        pend_d[0] = 1'b0;
        cnt_d[0]  = '0;
        if (issue_wr) begin
            last_v_d  = 1'b1;
            last_rd_d = sb.issue_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= '0;
            last_v_q  <= 1'b0;
            last_rd_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pend_q    <= pend_d;
            last_v_q  <= last_v_d;
            last_rd_q <= last_rd_d;
            for (int i = 0; i < NREGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
endmodule

// File: tb/tb_kamacore_hazard_scoreboard.sv
// Directed and random checks of the hazard scoreboard against a ready-time reference model.
module tb_kamacore_hazard_scoreboard;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int LAT_W = 3;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    int   cyc;

    // Reference model: a pending register is readable once the cycle count reaches ready_at.
    bit   m_pend  [NREGS];
    int   m_ready [NREGS];
    int   m_last_cyc;
    int   m_last_rd;

    kamacore_hazard_scoreboard_if #(.NREGS(NREGS), .AW(AW), .LAT_W(LAT_W)) sb_if ();

    kamacore_hazard_scoreboard #(.NREGS(NREGS), .AW(AW), .LAT_W(LAT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NREGS; i++) begin
            m_pend[i]  = 1'b0;
            m_ready[i] = 0;
        end
        m_last_cyc = -10;
        m_last_rd  = 0;
    endfunction

    function automatic bit model_read_blocked(input int r);
        return (r != 0) && m_pend[r] && (cyc < m_ready[r]);
    endfunction

    function automatic bit model_stall();
        bit s;
        s = 1'b0;
        if (sb_if.rs1_used && model_read_blocked(int'(sb_if.rs1_a))) s = 1'b1;
        if (sb_if.rs2_used && model_read_blocked(int'(sb_if.rs2_a))) s = 1'b1;
        if (sb_if.issue_we && sb_if.issue_rd != 0 && m_pend[sb_if.issue_rd]) s = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < NREGS; i++) m[i] = m_pend[i];
        return m;
    endfunction

    function automatic void model_update(input bit acc);
        int wr;
        if (sb_if.wb_valid && sb_if.wb_rd != 0) m_pend[sb_if.wb_rd] = 1'b0;
        if (sb_if.kill_ex && m_last_cyc == cyc - 1 && m_last_rd != 0) m_pend[m_last_rd] = 1'b0;
        wr = int'(sb_if.issue_rd);
        if (acc && sb_if.issue_we && wr != 0) begin
            m_pend[wr]  = 1'b1;
            m_ready[wr] = cyc + 1 + int'(sb_if.issue_lat);
            m_last_cyc  = cyc;
            m_last_rd   = wr;
        end else begin
            m_last_cyc = -10;
        end
    endfunction

    task automatic idle_inputs();
        sb_if.rs1_a = '0; sb_if.rs1_used = 1'b0;
        sb_if.rs2_a = '0; sb_if.rs2_used = 1'b0;
        sb_if.issue_valid = 1'b0; sb_if.issue_we = 1'b0;
        sb_if.issue_rd = '0; sb_if.issue_lat = '0;
        sb_if.kill_ex = 1'b0; sb_if.wb_valid = 1'b0; sb_if.wb_rd = '0;
    endtask

    task automatic issue(input int rd, input int lat);
        sb_if.issue_valid = 1'b1; sb_if.issue_we = 1'b1;
        sb_if.issue_rd = AW'(rd); sb_if.issue_lat = LAT_W'(lat);
    endtask

    // Called just after a falling edge with inputs applied: check, clock once, advance the model.
    task automatic step();
        bit es;
        bit acc;
        #1;
        es = model_stall();
        check("stall", {31'd0, sb_if.stall}, {31'd0, es});
        check("pending_mask", sb_if.pending_mask, model_mask());
        check("busy", {31'd0, sb_if.busy}, {31'd0, |model_mask()});
        acc = sb_if.issue_valid && !es;
        @(posedge clk);
        model_update(acc);
        cyc++;
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        model_clear();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("rst_mask", sb_if.pending_mask, 32'd0);
        check("rst_busy", {31'd0, sb_if.busy}, 32'd0);
        check("rst_stall", {31'd0, sb_if.stall}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Load-use with latency 1
        issue(5, 1); step();
        sb_if.rs1_a = 5'd5; sb_if.rs1_used = 1'b1; #1;
        check("lu_stall_c1", {31'd0, sb_if.stall}, 32'd1); step();
        sb_if.rs1_a = 5'd5; sb_if.rs1_used = 1'b1; #1;
        check("lu_stall_c2", {31'd0, sb_if.stall}, 32'd0);
        check("lu_pend_c2", {31'd0, sb_if.pending_mask[5]}, 32'd1); step();
        step();
        sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd5; step();
        check("lu_pend_after_wb", sb_if.pending_mask, 32'd0);
        check("lu_busy_after_wb", {31'd0, sb_if.busy}, 32'd0);

        // ALU back-to-back and unused-source read
        issue(7, 0); step();
        sb_if.rs2_a = 5'd7; sb_if.rs2_used = 1'b1; #1;
        check("alu_b2b", {31'd0, sb_if.stall}, 32'd0); step();
        sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd7; step();
        issue(7, 3); step();
        sb_if.rs1_a = 5'd7; sb_if.rs1_used = 1'b0; #1;
        check("unused_src", {31'd0, sb_if.stall}, 32'd0); step();
        sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd7; step();

        // WAW stalls until writeback; a stalled issue leaves state untouched
        issue(3, 4); step();
        for (int k = 0; k < 6; k++) begin
            issue(3, 1); sb_if.issue_lat = LAT_W'(1); #1;
            check("waw_stall", {31'd0, sb_if.stall}, 32'd1); step();
        end
        sb_if.rs1_a = 5'd3; sb_if.rs1_used = 1'b1; issue(10, 2); #1;
        check("waw_hold_read", {31'd0, sb_if.stall}, 32'd0); step();
        check("accepted_rd10", {31'd0, sb_if.pending_mask[10]}, 32'd1);
        sb_if.rs1_a = 5'd10; sb_if.rs1_used = 1'b1; issue(12, 2); #1;
        check("stalled_issue_stall", {31'd0, sb_if.stall}, 32'd1); step();
        check("stalled_issue_ignored", {31'd0, sb_if.pending_mask[12]}, 32'd0);
        sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd3; step();
        issue(3, 1); #1;
        check("waw_release", {31'd0, sb_if.stall}, 32'd0); step();
        sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd3; step();
        sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd10; step();

        // x0 is never tracked
        issue(0, 7); step();
        check("x0_mask", sb_if.pending_mask, 32'd0);
        issue(0, 7); sb_if.rs1_a = 5'd0; sb_if.rs1_used = 1'b1; #1;
        check("x0_nostall", {31'd0, sb_if.stall}, 32'd0); step();

        // Kill right after issue clears; late kill has no effect
        issue(9, 2); step();
        sb_if.kill_ex = 1'b1; step();
        check("kill_clear", {31'd0, sb_if.pending_mask[9]}, 32'd0);
        sb_if.rs1_a = 5'd9; sb_if.rs1_used = 1'b1; #1;
        check("kill_read", {31'd0, sb_if.stall}, 32'd0); step();
        issue(9, 2); step();
        step();
        sb_if.kill_ex = 1'b1; step();
        check("late_kill", {31'd0, sb_if.pending_mask[9]}, 32'd1);
        sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd9; step();

        // Async reset mid-cycle with three pending entries
        issue(4, 5); step();
        issue(6, 5); step();
        issue(8, 5); step();
        check("pre_rst_mask", sb_if.pending_mask, 32'h0000_0150);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_mask", sb_if.pending_mask, 32'd0);
        check("async_rst_busy", {31'd0, sb_if.busy}, 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 4; r <= 8; r += 2) begin
            sb_if.rs1_a = AW'(r); sb_if.rs1_used = 1'b1; #1;
            check("post_rst_read", {31'd0, sb_if.stall}, 32'd0); step();
        end

        // Random traffic on a small register window to provoke hazards
        for (int k = 0; k < 600; k++) begin
            sb_if.rs1_a = AW'($urandom_range(0, 7)); sb_if.rs1_used = 1'($urandom_range(0, 1));
            sb_if.rs2_a = AW'($urandom_range(0, 7)); sb_if.rs2_used = 1'($urandom_range(0, 1));
            sb_if.issue_valid = 1'($urandom_range(0, 1));
            sb_if.issue_we = ($urandom_range(0, 3) != 0);
            sb_if.issue_rd = AW'($urandom_range(0, 7));
            sb_if.issue_lat = LAT_W'($urandom_range(0, 7));
            sb_if.kill_ex = ($urandom_range(0, 6) == 0);
            sb_if.wb_valid = ($urandom_range(0, 2) == 0);
            sb_if.wb_rd = AW'($urandom_range(0, 7));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
